// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA test-pattern generator: mode codes, colour
// masks and the colour-bar lookup.
package vga_pattern_pkg;

    localparam logic [2:0] MODE_GRAD  = 3'd0;
    localparam logic [2:0] MODE_BARS  = 3'd1;
    localparam logic [2:0] MODE_CHECK = 3'd2;
    localparam logic [2:0] MODE_GRID  = 3'd3;
    localparam logic [2:0] MODE_BOX   = 3'd4;

    // Colour masks are {B,G,R}, one bit per channel, expanded to full scale later.
    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_WHITE = 3'b111;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    function automatic logic [2:0] bar_rgb(input logic [2:0] k);
        return {k[2], k[1], k[0]};
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box state: position, direction and colour per axis, advanced once
// per frame on i_step.
module vga_box_mover
    import vga_pattern_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 4
)(
    input  logic               vga_clk,
    input  logic               vga_rst,
    input  logic               i_step,
    output logic [COORD_W-1:0] o_box_x,
    output logic [COORD_W-1:0] o_box_y,
    output dir_e               o_dir_x,
    output dir_e               o_dir_y,
    output logic [2:0]         o_box_col
);

    localparam int XW = COORD_W + 1;
    localparam logic [XW-1:0] STEP  = XW'(BOX_STEP);
    localparam logic [XW-1:0] MAX_X = XW'(H_ACTIVE - BOX_SIZE);
    localparam logic [XW-1:0] MAX_Y = XW'(V_ACTIVE - BOX_SIZE);

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        dir_e               dir;
        logic               bounce;
    } axis_t;

    logic [COORD_W-1:0] r_box_x, r_box_y;
    dir_e               r_dir_x, r_dir_y;
    logic [2:0]         r_box_col;
    axis_t              w_nx, w_ny;

    // One extra bit on the sums so a step past the edge is clamped, never wrapped.
    function automatic axis_t axis_next(input logic [COORD_W-1:0] pos, input dir_e dir,
                                        input logic [XW-1:0] max_pos);
        logic [XW-1:0] p;
        axis_t         n;
        p        = {1'b0, pos};
        n.pos    = pos;
        n.dir    = dir;
        n.bounce = 1'b0;
        if (dir == DIR_POS) begin
            if (p + STEP >= max_pos) begin
                n.pos    = COORD_W'(max_pos);
                n.dir    = DIR_NEG;
                n.bounce = 1'b1;
            end else begin
                n.pos = COORD_W'(p + STEP);
            end
        end else begin
            if (p <= STEP) begin
                n.pos    = '0;
                n.dir    = DIR_POS;
                n.bounce = 1'b1;
            end else begin
                n.pos = COORD_W'(p - STEP);
            end
        end
        return n;
    endfunction

    always_comb begin
        w_nx = axis_next(r_box_x, r_dir_x, MAX_X);
        w_ny = axis_next(r_box_y, r_dir_y, MAX_Y);
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            r_box_x   <= '0;
            r_box_y   <= '0;
            r_dir_x   <= DIR_POS;
            r_dir_y   <= DIR_POS;
            r_box_col <= 3'd1;
        end else if (i_step) begin
            r_box_x <= w_nx.pos;
            r_box_y <= w_ny.pos;
            r_dir_x <= w_nx.dir;
            r_dir_y <= w_ny.dir;
            if (w_nx.bounce || w_ny.bounce)
                r_box_col <= (r_box_col == 3'd7) ? 3'd1 : r_box_col + 3'd1;
        end
    end

    assign o_box_x   = r_box_x;
    assign o_box_y   = r_box_y;
    assign o_dir_x   = r_dir_x;
    assign o_dir_y   = r_dir_y;
    assign o_box_col = r_box_col;

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator: frame-synchronous mode register,
// frame counter, per-mode colour selection and a one-cycle output register.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int CH_W      = 4,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int CHK_LOG2  = 5,
    parameter int GRID_LOG2 = 6,
    parameter int BOX_SIZE  = 32,
    parameter int BOX_STEP  = 4
)(
    input  logic                vga_clk,
    input  logic                vga_rst,
    input  logic [COORD_W-1:0]  x_pos,
    input  logic [COORD_W-1:0]  y_pos,
    input  logic                pix_active,
    input  logic                frame_start,
    input  logic [2:0]          mode_sel,
    output logic [3*CH_W-1:0]   pixel_data,
    output logic                pixel_vld,
    output logic [2:0]          cur_mode,
    output logic [7:0]          frame_cnt
);

    localparam int XW    = COORD_W + 1;
    localparam int BAR_W = H_ACTIVE / 8;

    logic [3*CH_W-1:0]  r_pixel_data, w_pixel;
    logic               r_pixel_vld;
    logic [2:0]         r_cur_mode, w_bar_k, w_box_col;
    logic [7:0]         r_frame_cnt;
    logic [COORD_W-1:0] w_box_x, w_box_y;
    dir_e               w_dir_x, w_dir_y;
    logic               w_in_box, w_grid_on;

    vga_box_mover #(
        .COORD_W (COORD_W),
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .BOX_SIZE(BOX_SIZE),
        .BOX_STEP(BOX_STEP)
    ) u_box (
        .vga_clk  (vga_clk),
        .vga_rst  (vga_rst),
        .i_step   (frame_start),
        .o_box_x  (w_box_x),
        .o_box_y  (w_box_y),
        .o_dir_x  (w_dir_x),
        .o_dir_y  (w_dir_y),
        .o_box_col(w_box_col)
    );

    function automatic logic [3*CH_W-1:0] expand(input logic [2:0] m);
        return {{CH_W{m[2]}}, {CH_W{m[1]}}, {CH_W{m[0]}}};
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_bar_k = 3'd0;
        for (int i = 1; i < 8; i++)
            if ({1'b0, x_pos} >= XW'(i * BAR_W))
                w_bar_k = 3'(i);
    end

    assign w_in_box = ({1'b0, x_pos} >= {1'b0, w_box_x}) &&
                      ({1'b0, x_pos} <  {1'b0, w_box_x} + XW'(BOX_SIZE)) &&
                      ({1'b0, y_pos} >= {1'b0, w_box_y}) &&
                      ({1'b0, y_pos} <  {1'b0, w_box_y} + XW'(BOX_SIZE));

    assign w_grid_on = (x_pos[GRID_LOG2-1:0] == '0) || (y_pos[GRID_LOG2-1:0] == '0) ||
                       (x_pos == COORD_W'(H_ACTIVE - 1)) || (y_pos == COORD_W'(V_ACTIVE - 1));

    always_comb begin
        w_pixel = '0;
        case (r_cur_mode)
            MODE_GRAD:  w_pixel = {x_pos[CH_W+2:3], y_pos[CH_W+2:3], r_frame_cnt[CH_W-1:0]};
            MODE_BARS:  w_pixel = expand(bar_rgb(w_bar_k));
            MODE_CHECK: w_pixel = expand((x_pos[CHK_LOG2] ^ y_pos[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK);
            MODE_GRID:  w_pixel = expand(w_grid_on ? RGB_WHITE : RGB_BLACK);
            MODE_BOX:   w_pixel = expand(w_in_box ? w_box_col : RGB_BLACK);
            default:    w_pixel = '0;
        endcase
    end

    // Mode and counter change only on frame_start; the pixel of that cycle still uses old state.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            r_pixel_data <= '0;
            r_pixel_vld  <= 1'b0;
            r_cur_mode   <= MODE_GRAD;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_pixel_vld  <= pix_active;
            r_pixel_data <= pix_active ? w_pixel : '0;
            if (frame_start) begin
                r_cur_mode  <= mode_sel;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign pixel_data = r_pixel_data;
    assign pixel_vld  = r_pixel_vld;
    assign cur_mode   = r_cur_mode;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: vector table, directed corner
// sequences and randomized cycles against a frame-level reference model.
module tb_vga_pattern_gen;
    import vga_pattern_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x_pos, y_pos;
    logic        pix_active, frame_start;
    logic [2:0]  mode_sel;
    logic [11:0] pixel_data;
    logic        pixel_vld;
    logic [2:0]  cur_mode;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .vga_clk    (clk),
        .vga_rst    (rst),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .pix_active (pix_active),
        .frame_start(frame_start),
        .mode_sel   (mode_sel),
        .pixel_data (pixel_data),
        .pixel_vld  (pixel_vld),
        .cur_mode   (cur_mode),
        .frame_cnt  (frame_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    // Reference model: frame-level state in plain integers.
    int m_mode, m_fcnt, m_bx, m_by, m_dx, m_dy, m_col;

    task automatic model_reset();
        m_mode = 0; m_fcnt = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_col = 1;
    endtask

    task automatic axis(inout int p, inout int d, input int mx, output bit b);
        b = 0;
        if (d > 0) begin
            if (p + 4 >= mx) begin p = mx; d = -1; b = 1; end
            else p = p + 4;
        end else begin
            if (p <= 4) begin p = 0; d = 1; b = 1; end
            else p = p - 4;
        end
    endtask

    task automatic model_frame(input int ms);
        bit bxb, byb;
        m_mode = ms;
        m_fcnt = (m_fcnt + 1) % 256;
        axis(m_bx, m_dx, 640 - 32, bxb);
        axis(m_by, m_dy, 480 - 32, byb);
        if (bxb || byb) m_col = m_col % 7 + 1;
    endtask

    function automatic logic [11:0] full(input int b, input int g, input int r);
        return {(b != 0) ? 4'hF : 4'h0, (g != 0) ? 4'hF : 4'h0, (r != 0) ? 4'hF : 4'h0};
    endfunction

    function automatic logic [11:0] model_pixel(input int xx, input int yy, input bit a);
        int k;
        if (!a) return 12'h000;
        case (m_mode)
            0: return 12'(((xx / 8) % 16) * 256 + ((yy / 8) % 16) * 16 + (m_fcnt % 16));
            1: begin
                k = xx / 80;
                if (k > 7) k = 7;
                return full(k & 4, k & 2, k & 1);
            end
            2: return (((xx / 32) + (yy / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
            3: return (xx % 64 == 0 || yy % 64 == 0 || xx == 639 || yy == 479) ? 12'hFFF : 12'h000;
            4: begin
                if (xx >= m_bx && xx < m_bx + 32 && yy >= m_by && yy < m_by + 32)
                    return full(m_col & 4, m_col & 2, m_col & 1);
                return 12'h000;
            end
            default: return 12'h000;
        endcase
    endfunction

    // One clock: drive inputs, advance, compare against the model.
    task automatic cycle(input string tag, input int xx, input int yy, input bit a,
                         input bit f, input int ms, input bit do_check);
        logic [11:0] ep;
        bit          ev;
        ep = rst ? 12'h000 : model_pixel(xx, yy, a);
        ev = rst ? 1'b0 : a;
        x_pos = 10'(xx); y_pos = 10'(yy); pix_active = a; frame_start = f; mode_sel = 3'(ms);
        @(posedge clk); #1;
        if (rst) model_reset();
        else if (f) model_frame(ms);
        if (do_check) begin
            check({tag, "/pix"},  pixel_data, ep);
            check({tag, "/vld"},  pixel_vld,  ev);
            check({tag, "/mode"}, cur_mode,   m_mode);
            check({tag, "/fcnt"}, frame_cnt,  m_fcnt);
        end
    endtask

    task automatic rand_pixel(input string tag, input int ms);
        cycle(tag, $urandom_range(639), $urandom_range(479), 1'($urandom_range(3) != 0), 0, ms, 1);
    endtask

    task automatic set_mode(input int m);
        if (m_mode != m) cycle("setmode", 0, 0, 0, 1, m, 1);
    endtask

    typedef struct {
        int          mode;
        int          x;
        int          y;
        bit          act;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b1; x_pos = '0; y_pos = '0; pix_active = 0; frame_start = 0; mode_sel = '0;
        model_reset();
        cycle("init", 0, 0, 0, 0, 0, 1);
        cycle("init", 0, 0, 0, 0, 0, 1);
        rst = 1'b0;

        // Reset mid-frame in mode 4 with the box already moving, frame_start pending.
        for (int i = 0; i < 6; i++) begin
            cycle("pre", 0, 0, 0, 1, 4, 1);
            rand_pixel("pre", 4);
        end
        check("pre/box_x", dut.w_box_x, 24);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle("rst", m_bx, m_by, 1, (i == 1), 4, 1);
        check("rst/pix",     pixel_data, 12'h000);
        check("rst/mode",    cur_mode, 0);
        check("rst/box_x",   dut.w_box_x, 0);
        check("rst/box_y",   dut.w_box_y, 0);
        check("rst/box_col", dut.w_box_col, 1);
        check("rst/dir_x",   dut.w_dir_x, DIR_POS);
        rst = 1'b0;

        // Vector table: bars, checker, grid, reserved modes, blanking.
        vecs.push_back('{1, 0,   0,   1, 12'h000});
        vecs.push_back('{1, 79,  10,  1, 12'h000});
        vecs.push_back('{1, 80,  10,  1, 12'h00F});
        vecs.push_back('{1, 160, 10,  1, 12'h0F0});
        vecs.push_back('{1, 320, 10,  1, 12'hF00});
        vecs.push_back('{1, 639, 10,  1, 12'hFFF});
        vecs.push_back('{2, 32,  0,   1, 12'hFFF});
        vecs.push_back('{2, 0,   0,   1, 12'h000});
        vecs.push_back('{2, 32,  32,  1, 12'h000});
        vecs.push_back('{2, 31,  32,  1, 12'hFFF});
        vecs.push_back('{2, 32,  0,   0, 12'h000});
        vecs.push_back('{3, 0,   5,   1, 12'hFFF});
        vecs.push_back('{3, 5,   5,   1, 12'h000});
        vecs.push_back('{3, 639, 5,   1, 12'hFFF});
        vecs.push_back('{3, 5,   479, 1, 12'hFFF});
        vecs.push_back('{3, 63,  63,  1, 12'h000});
        vecs.push_back('{3, 5,   64,  1, 12'hFFF});
        vecs.push_back('{5, 100, 100, 1, 12'h000});
        vecs.push_back('{7, 0,   0,   1, 12'h000});
        foreach (vecs[i]) begin
            set_mode(vecs[i].mode);
            cycle("vec", vecs[i].x, vecs[i].y, vecs[i].act, 0, vecs[i].mode, 1);
            check($sformatf("vec%0d/pix", i), pixel_data, vecs[i].exp);
            check($sformatf("vec%0d/vld", i), pixel_vld, vecs[i].act);
        end

        // Mode switch requested mid-frame takes effect only at the next frame_start.
        set_mode(1);
        for (int i = 0; i < 3; i++) begin
            cycle("sw", 100 + i, 10, 1, 0, 2, 1);
            check("sw/hold", cur_mode, 1);
        end
        cycle("sw", 80, 10, 1, 1, 2, 1);
        check("sw/old_pix", pixel_data, 12'h00F);
        check("sw/new", cur_mode, 2);
        cycle("sw", 32, 0, 1, 0, 2, 1);
        check("sw/chk32", pixel_data, 12'hFFF);
        cycle("sw", 0, 0, 1, 0, 2, 1);
        check("sw/chk0", pixel_data, 12'h000);

        // Box bounce sequence from reset.
        rst = 1'b1;
        cycle("brst", 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        for (int i = 1; i <= 153; i++) begin
            cycle("box", 0, 0, 0, 1, 4, 1);
            rand_pixel("box", 4);
            rand_pixel("box", 4);
            if (i == 112) begin
                check("box112/y",   dut.w_box_y, 448);
                check("box112/col", dut.w_box_col, 2);
            end
            if (i == 152) begin
                check("box152/x",     dut.w_box_x, 608);
                check("box152/dir_x", dut.w_dir_x, DIR_NEG);
                check("box152/y",     dut.w_box_y, 288);
                check("box152/col",   dut.w_box_col, 3);
                cycle("box", 608, 288, 1, 0, 4, 1);
                check("box152/in",  pixel_data, 12'h0FF);
                cycle("box", 607, 288, 1, 0, 4, 1);
                check("box152/out", pixel_data, 12'h000);
                cycle("box", 639, 319, 1, 0, 4, 1);
                check("box152/corner", pixel_data, 12'h0FF);
            end
            if (i == 153) check("box153/x", dut.w_box_x, 604);
        end

        // Frame counter wrap; gradient red tracks the counter.
        rst = 1'b1;
        cycle("frst", 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            cycle("fc", 0, 0, 0, 1, 0, 1);
            rand_pixel("fc", 0);
            if (i == 5) begin
                cycle("fc", 8, 16, 1, 0, 0, 1);
                check("fc5/grad", pixel_data, 12'h125);
            end
        end
        check("fc256/wrap", frame_cnt, 0);
        cycle("fc", 0, 0, 1, 0, 0, 1);
        check("fc256/grad", pixel_data, 12'h000);

        // Randomized traffic with occasional frame starts, mode requests and resets.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(199) == 0);
            cycle("rnd", $urandom_range(639), $urandom_range(479), 1'($urandom_range(3) != 0),
                  ($urandom_range(15) == 0), $urandom_range(7), 1);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
